// File: rtl/rv32i_pkg.sv
// Shared RV32I memory-access definitions: load/store funct3 encodings and the
// data-memory responder state type.
package rv32i_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } dmem_state_t;

    function automatic logic load_funct3_ok(input logic [2:0] funct3);
        logic ok;
        case (funct3)
            MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic store_funct3_ok(input logic [2:0] funct3);
        logic ok;
        case (funct3)
            MEM_B, MEM_H, MEM_W: ok = 1'b1;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane helper for a 32-bit little-endian data memory: store byte enables
// and data replication, load extraction with sign/zero extension, misalignment.
module mem_lane_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted_s;

    assign shifted_s = mem_word >> {addr_lo, 3'b000};

    // Store-side lane selection, keyed on access size only (funct3[1:0]).
    always_comb begin
        byte_en    = 4'b0000;
        store_word = 32'h0000_0000;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << addr_lo;
                store_word = {4{store_data[7:0]}};
            end
            2'b01: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
                misaligned = addr_lo[0];
            end
            2'b10: begin
                byte_en    = 4'b1111;
                store_word = store_data;
                misaligned = (addr_lo != 2'b00);
            end
            default: begin
                byte_en    = 4'b0000;
                store_word = 32'h0000_0000;
                misaligned = 1'b0;
            end
        endcase
    end

    // Load-side extraction from the addressed lane, then extension.
    always_comb begin
        load_data = 32'h0000_0000;
        case (funct3)
            MEM_B:   load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            MEM_H:   load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            MEM_W:   load_data = shifted_s;
            MEM_BU:  load_data = {24'h00_0000, shifted_s[7:0]};
            MEM_HU:  load_data = {16'h0000, shifted_s[15:0]};
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, waits
// LATENCY cycles, commits to word storage, then holds the response until taken.
module dmem_responder
    import rv32i_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [2:0] LAT_LAST = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

    dmem_state_t state_r;
    dmem_state_t state_nxt_s;
    logic [2:0]  cnt_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;

    logic        cap_read_r;
    logic        cap_write_r;
    logic [2:0]  cap_funct3_r;
    logic [31:0] cap_addr_r;
    logic [31:0] cap_wdata_r;

    logic        op_read_s;
    logic        op_write_s;
    logic [2:0]  op_funct3_s;
    logic [31:0] op_addr_s;
    logic [31:0] op_wdata_s;
    logic        op_range_err_s;
    logic        op_f3_err_s;
    logic        op_err_s;
    logic        misaligned_s;
    logic [3:0]  byte_en_s;
    logic [31:0] store_word_s;
    logic [31:0] load_data_s;
    logic [31:0] word_s;
    logic        accept_s;
    logic        commit_s;
    logic [IDX_W-1:0] idx_s;

    logic [31:0] mem_r [DEPTH_WORDS];

    // req_ready_r is held low by reset, so no accept and no commit can occur while rst is high.
    assign accept_s = req_valid && req_ready_r;
    assign commit_s = ((LATENCY == 0) && accept_s) ||
                      ((state_r == ST_WAIT) && (cnt_r == LAT_LAST));

    // Zero-latency commits in IDLE straight from the live request.
    assign op_read_s   = (state_r == ST_IDLE) ? req_read   : cap_read_r;
    assign op_write_s  = (state_r == ST_IDLE) ? req_write  : cap_write_r;
    assign op_funct3_s = (state_r == ST_IDLE) ? req_funct3 : cap_funct3_r;
    assign op_addr_s   = (state_r == ST_IDLE) ? req_addr   : cap_addr_r;
    assign op_wdata_s  = (state_r == ST_IDLE) ? req_wdata  : cap_wdata_r;

    assign idx_s          = op_addr_s[IDX_W+1:2];
    assign word_s         = mem_r[idx_s];
    assign op_range_err_s = ({1'b0, op_addr_s[31:2]} >= 31'(DEPTH_WORDS));
    assign op_f3_err_s    = op_read_s ? !load_funct3_ok(op_funct3_s)
                                      : !store_funct3_ok(op_funct3_s);
    assign op_err_s       = (op_read_s == op_write_s) || op_f3_err_s ||
                            misaligned_s || op_range_err_s;

    mem_lane_align u_align (
        .funct3     (op_funct3_s),
        .addr_lo    (op_addr_s[1:0]),
        .store_data (op_wdata_s),
        .mem_word   (word_s),
        .byte_en    (byte_en_s),
        .store_word (store_word_s),
        .load_data  (load_data_s),
        .misaligned (misaligned_s)
    );

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == LAT_LAST) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, wait counter and handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 3'd0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            if ((state_r == ST_WAIT) && (cnt_r != LAT_LAST)) begin
                cnt_r <= cnt_r + 3'd1;
            end else begin
                cnt_r <= 3'd0;
            end
        end
    end

    // Request capture on acceptance; later req_* activity is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_read_r   <= 1'b0;
            cap_write_r  <= 1'b0;
            cap_funct3_r <= 3'b000;
            cap_addr_r   <= 32'h0000_0000;
            cap_wdata_r  <= 32'h0000_0000;
        end else if (accept_s) begin
            cap_read_r   <= req_read;
            cap_write_r  <= req_write;
            cap_funct3_r <= req_funct3;
            cap_addr_r   <= req_addr;
            cap_wdata_r  <= req_wdata;
        end
    end

    // Response payload: set at commit, held through RESP, cleared on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else if (commit_s) begin
            rsp_err_r   <= op_err_s;
            rsp_rdata_r <= (op_read_s && !op_err_s) ? load_data_s : 32'h0000_0000;
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end
    end

    // Storage array is deliberately not reset; only committed, error-free stores write.
    always_ff @(posedge clk) begin
        if (commit_s && op_write_s && !op_err_s) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= store_word_s[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-array memory model.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 3;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_read;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ref_mem [DEPTH*4];

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural model: little-endian byte memory, RV32I load/store rules.
    function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rdata, output logic err);
        int unsigned size;
        logic        f3_ok;
        logic [31:0] v;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        f3_ok = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        err   = (rd == wr) || !f3_ok || ((a % size) != 0) || ((a / 4) >= DEPTH);
        rdata = 32'h0;
        if (!err && rd) begin
            v = 32'h0;
            for (int i = 0; i < int'(size); i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
            rdata = v;
        end else if (!err) begin
            for (int i = 0; i < int'(size); i++) ref_mem[a + i] = wd[8*i +: 8];
        end
    endfunction

    // One complete transaction; called and returning on a falling edge.
    task automatic do_txn(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold,
                          input string tag, output logic [31:0] got_d, output logic got_e);
        logic [31:0] exp_d;
        logic        exp_e;
        int          n;
        logic        bad;
        model(rd, wr, f3, addr, wd, exp_d, exp_e);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'h1);
        req_valid  = 1'b1;
        req_read   = rd;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        req_read   = 1'($urandom);
        req_write  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        n   = 1;
        bad = 1'b0;
        while (!rsp_valid && n < 20) begin
            if (req_ready) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(LAT + 1));
        got_d = rsp_rdata;
        got_e = rsp_err;
        check({tag, "_err"}, 32'(got_e), 32'(exp_e));
        check({tag, "_rdata"}, got_d, exp_d);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== got_d || rsp_err !== got_e || req_ready !== 1'b0)
                bad = 1'b1;
        end
        check({tag, "_busy_stable"}, 32'(bad), 32'h0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_release"}, {30'h0, rsp_valid, req_ready}, 32'h1);
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] mask;
        int          kind;
        int          r;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_read   = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'h1);

        for (int w = 0; w < DEPTH; w++) begin
            do_txn(1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom, 0, "init", d, e);
        end

        do_txn(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1, "sw_10", d, e);
        do_txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_10", d, e);
        check("lw_10_const", d, 32'hDEAD_BEEF);
        check("lw_10_err_const", 32'(e), 32'h0);
        do_txn(1'b0, 1'b1, 3'b000, 32'h13, 32'h0000_0080, 0, "sb_13", d, e);
        do_txn(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 2, "lb_13", d, e);
        check("lb_13_const", d, 32'hFFFF_FF80);
        do_txn(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 0, "lbu_13", d, e);
        check("lbu_13_const", d, 32'h0000_0080);
        do_txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_10b", d, e);
        check("lw_10b_const", d, 32'h80AD_BEEF);
        do_txn(1'b1, 1'b0, 3'b001, 32'h11, 32'h0, 0, "lh_11", d, e);
        check("lh_11_err_const", {31'h0, e}, 32'h1);
        check("lh_11_rdata_const", d, 32'h0);
        do_txn(1'b0, 1'b1, 3'b010, 32'h12, 32'h1111_2222, 0, "sw_12", d, e);
        check("sw_12_err_const", {31'h0, e}, 32'h1);
        do_txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5, "lw_10c_stall5", d, e);
        check("lw_10c_const", d, 32'h80AD_BEEF);
        do_txn(1'b1, 1'b0, 3'b010, 32'(DEPTH * 4), 32'h0, 0, "lw_oor", d, e);
        check("lw_oor_err_const", {31'h0, e}, 32'h1);
        do_txn(1'b1, 1'b1, 3'b010, 32'h10, 32'h0, 0, "rd_wr_both", d, e);

        for (int t = 0; t < 250; t++) begin
            kind = $urandom_range(0, 9);
            rd   = (kind < 5);
            wr   = !rd;
            if (kind == 9) begin
                rd = 1'($urandom);
                wr = rd;
            end
            f3 = 3'($urandom_range(0, 2));
            if (rd && f3 != 3'd2 && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
            if (kind == 8) f3 = 3'($urandom_range(0, 7));
            mask = (f3[1:0] == 2'd0) ? 32'hFFFF_FFFF : (f3[1:0] == 2'd1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
            r = $urandom_range(0, 9);
            if (r == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
            else if (r == 1) a = $urandom;
            else if (r == 2) a = 32'($urandom_range(0, DEPTH * 4 - 1));
            else a = 32'($urandom_range(0, DEPTH * 4 - 1)) & mask;
            do_txn(rd, wr, f3, a, $urandom, $urandom_range(0, 3), "rand", d, e);
        end

        // Store accepted, then reset while it is still waiting to commit.
        req_valid  = 1'b1;
        req_read   = 1'b0;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h1234_5678;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("midop_not_ready", 32'(req_ready), 32'h0);
        rst = 1'b1;
        #1;
        check("midop_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("post_rst_req_ready", 32'(req_ready), 32'h1);
        do_txn(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 0, "lw_20_after_rst", d, e);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning 32-bit words of storage (power of two).
REQ-002 SHALL have parameter LATENCY, default 1, meaning wait cycles between request acceptance and commit (0..7).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  core request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_read  input  1  load request (control_t.mem_read).
REQ-008 SHALL have port req_write  input  1  store request (control_t.mem_write).
REQ-009 SHALL have port req_funct3  input  3  size/sign (control_t.mem_funct3).
REQ-010 SHALL have port req_addr  input  32  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data, LSB-aligned.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  core accepts response.
REQ-014 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  request rejected, no side effect.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; with LATENCY=0, IDLE -> RESP directly.
REQ-017 SHALL assert req_ready only in IDLE; accept on req_valid && req_ready and capture all req_* fields.
REQ-018 SHALL, in WAIT, count LATENCY cycles, then commit and enter RESP; req_* changes after acceptance are ignored.
REQ-019 SHALL commit at the WAIT->RESP (or IDLE->RESP) edge: stores write masked byte lanes; loads capture the addressed word.
REQ-020 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready; on rsp_valid && rsp_ready return to IDLE; no new request is accepted in that same cycle.
REQ-021 SHALL decode loads: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero; byte/half selected by addr[1:0].
REQ-022 SHALL decode stores: 000 SB (lane addr[1:0]), 001 SH (lanes addr[1]*2 +0/+1), 010 SW (all lanes), taking data from req_wdata low bits.
REQ-023 SHALL set rsp_err and suppress the write when: half access with addr[0]=1; word access with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS; funct3 not legal for the access type; req_read == req_write.
REQ-024 SHALL return rsp_rdata=0 when rsp_err=1 or for stores.
REQ-025 SHALL make a load following a store to the same word return the newly written data.

Reset
REQ-026 SHALL on rst: state IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1 after deassertion.
REQ-027 SHALL drop a store accepted but not yet committed when rst asserts mid-operation; storage contents are not reset.

Structure
REQ-028 SHALL place funct3 constants (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU) and the FSM state enum in rv32i_pkg.
REQ-029 SHALL use one combinational sub-module mem_lane_align: byte-enable generation, store data replication, load extraction/extension, misalignment detect.

Verification
REQ-030 SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_err=0, rsp_rdata=0xDEADBEEF.
REQ-031 SB 0x80 @0x13 over that word, LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-032 LH @0x11 -> rsp_err=1, rdata 0; SW @0x12 -> rsp_err=1 and LW @0x10 unchanged.
REQ-033 LATENCY=3, rsp_ready held 0 for 5 cycles -> rsp_valid exactly 4 cycles after acceptance, held stable, req_ready=0 throughout.
REQ-034 Accept SW 0x12345678 @0x20 with LATENCY=3, assert rst in WAIT -> after reset rsp_valid=0, req_ready=1, LW @0x20 returns the prior value.
